// File: rtl/ping_pong_checker_pkg.sv
// Shared definitions for the ping-pong counter checker: direction encodings,
// FSM state encodings and default counter geometry.
package ping_pong_checker_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int PPC_WIDTH = 4;
  localparam int PPC_MIN   = 0;
  localparam int PPC_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } ppc_state_e;

endpackage

// File: rtl/ppc_step_model.sv
// Combinational one-step model of a ping-pong counter: given the current
// {direction, count} and enable, produce the value expected on the next sample.
module ppc_step_model
  import ping_pong_checker_pkg::*;
#(
  parameter int WIDTH = PPC_WIDTH,
  parameter int MIN   = PPC_MIN,
  parameter int MAX   = PPC_MAX
) (
  input  logic             dir_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             enable_i,
  output logic             dir_o,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] next_count_s;

  // Step or hold, then turn around when the new value reaches an end point.
  always_comb begin
    next_count_s = count_i;
    dir_o        = dir_i;
    if (enable_i) begin
      if (dir_i == DIR_UP) begin
        next_count_s = count_i + ONE_C;
      end else begin
        next_count_s = count_i - ONE_C;
      end
      if (next_count_s == MAX_C) begin
        dir_o = DIR_DOWN;
      end else if (next_count_s == MIN_C) begin
        dir_o = DIR_UP;
      end else begin
        dir_o = dir_i;
      end
    end else begin
      next_count_s = count_i;
      dir_o        = dir_i;
    end
    count_o = next_count_s;
  end

endmodule

// File: rtl/ping_pong_checker.sv
// Observer for a ping-pong counter stream: locks onto a legal sample, tracks
// the predicted sequence, flags mismatches and counts legal direction reversals.
// Define PPC_CHK_RESYNC_EN to let the checker re-acquire after a fault.
module ping_pong_checker
  import ping_pong_checker_pkg::*;
#(
  parameter int WIDTH = PPC_WIDTH,
  parameter int MIN   = PPC_MIN,
  parameter int MAX   = PPC_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [7:0]       bounce_cnt,
  output logic [WIDTH-1:0] exp_count
);

  localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
  localparam logic [WIDTH:0]   SPAN_C = (WIDTH+1)'(MAX - MIN);

  ppc_state_e       state_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic [7:0]       bounce_q;
  logic [7:0]       bounce_d;
  logic [WIDTH-1:0] exp_count_q;
  logic             exp_dir_q;
  logic             prev_dir_q;

  logic             step_dir_s;
  logic [WIDTH-1:0] step_count_s;
  logic [WIDTH:0]   offset_s;
  logic             legal_s;
  logic             match_s;

  ppc_step_model #(
    .WIDTH(WIDTH),
    .MIN  (MIN),
    .MAX  (MAX)
  ) u_step (
    .dir_i   (direction),
    .count_i (count),
    .enable_i(enable),
    .dir_o   (step_dir_s),
    .count_o (step_count_s)
  );

  // Range check via a widened offset so below-MIN values wrap to a large number.
  always_comb begin
    offset_s = {1'b0, count} - {1'b0, MIN_C};
    legal_s  = (offset_s <= SPAN_C)
             && !((count == MAX_C) && (direction == DIR_UP))
             && !((count == MIN_C) && (direction == DIR_DOWN));
    match_s  = (count == exp_count_q) && (direction == exp_dir_q);
    if ((direction != prev_dir_q) && (bounce_q != 8'hFF)) begin
      bounce_d = bounce_q + 8'd1;
    end else begin
      bounce_d = bounce_q;
    end
  end

  // Checker FSM with prediction, bounce and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      bounce_q     <= 8'd0;
      exp_count_q  <= MIN_C;
      exp_dir_q    <= DIR_UP;
      prev_dir_q   <= DIR_UP;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (legal_s) begin
            state_q     <= ST_TRACK;
            locked_q    <= 1'b1;
            exp_count_q <= step_count_s;
            exp_dir_q   <= step_dir_s;
            prev_dir_q  <= direction;
          end else begin
            state_q      <= ST_FAULT;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b1;
            err_sticky_q <= 1'b1;
          end
        end
        ST_TRACK: begin
          // A mismatching sample never counts as a bounce.
          if (match_s) begin
            exp_count_q <= step_count_s;
            exp_dir_q   <= step_dir_s;
            prev_dir_q  <= direction;
            bounce_q    <= bounce_d;
          end else begin
            state_q      <= ST_FAULT;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b1;
            err_sticky_q <= 1'b1;
          end
        end
        ST_FAULT: begin
          locked_q <= 1'b0;
`ifdef PPC_CHK_RESYNC_EN
          state_q  <= ST_ACQUIRE;
`else
          state_q  <= ST_FAULT;
`endif
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign bounce_cnt = bounce_q;
  assign exp_count  = exp_count_q;

endmodule

// File: tb/tb_ping_pong_checker.sv
// Directed bench for ping_pong_checker: a vector table for reset/acquire/track/fault
// plus hand-written multi-cycle sequences for bounces, saturation, holds and resync.
module tb_ping_pong_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       direction;
  logic [3:0] count;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] bounce_cnt;
  logic [3:0] exp_count;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_cnt;
  logic       m_dir;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic [3:0] cnt;
    logic       lk;
    logic       pl;
    logic       st;
    logic [7:0] bc;
    logic [3:0] ec;
  } vec_t;

  vec_t vt [12];

  ping_pong_checker dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .direction (direction),
    .count     (count),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .bounce_cnt(bounce_cnt),
    .exp_count (exp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    direction = 1'b1;
    count     = 4'd0;
    tick();
    tick();
    rst   = 1'b0;
    m_cnt = 4'd0;
    m_dir = 1'b1;
  endtask

  // Present the reference counter value, then advance it as a real counter would.
  task automatic drive_step(input logic en_v);
    enable    = en_v;
    count     = m_cnt;
    direction = m_dir;
    tick();
    if (en_v) begin
      if (m_dir) m_cnt = m_cnt + 4'd1;
      else       m_cnt = m_cnt - 4'd1;
      if (m_cnt == 4'd15)     m_dir = 1'b0;
      else if (m_cnt == 4'd0) m_dir = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; direction = 1'b1; count = 4'd0;
    m_cnt = 4'd0; m_dir = 1'b1;
    @(negedge clk);

    //                rst   en    dir   cnt    lk    pl    st    bc     ec
    vt[0]  = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0, 4'd2};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0, 4'd3};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0, 4'd3};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0, 4'd4};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'd0, 4'd4};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 8'd0, 4'd4};
`ifdef PPC_CHK_RESYNC_EN
    vt[10] = '{1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 8'd0, 4'd7};
`else
    vt[10] = '{1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 8'd0, 4'd4};
`endif
    vt[11] = '{1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0};

    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; enable = vt[i].en; direction = vt[i].dir; count = vt[i].cnt;
      tick();
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vt[i].lk));
      chk($sformatf("vec%0d_pulse", i), 32'(err_pulse), 32'(vt[i].pl));
      chk($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(vt[i].st));
      chk($sformatf("vec%0d_bounce", i), 32'(bounce_cnt), 32'(vt[i].bc));
      chk($sformatf("vec%0d_exp", i), 32'(exp_count), 32'(vt[i].ec));
    end

    // Clean 40-cycle stream from 0/up: two turns, never an error.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive_step(1'b1);
      if (i >= 1) chk($sformatf("run_locked_%0d", i), 32'(locked), 32'd1);
    end
    chk("run_bounce", 32'(bounce_cnt), 32'd2);
    chk("run_sticky", 32'(err_sticky), 32'd0);
    chk("run_exp", 32'(exp_count), 32'd10);

    // Locked at 7/up, inject 9, then resume a legal stream.
    do_reset();
    for (int i = 0; i < 8; i++) drive_step(1'b1);
    chk("inj_pre_locked", 32'(locked), 32'd1);
    chk("inj_pre_exp", 32'(exp_count), 32'd8);
    enable = 1'b1; direction = 1'b1; count = 4'd9;
    tick();
    chk("inj_pulse", 32'(err_pulse), 32'd1);
    chk("inj_sticky", 32'(err_sticky), 32'd1);
    chk("inj_locked", 32'(locked), 32'd0);
    count = 4'd9;
    tick();
    chk("inj_pulse_once", 32'(err_pulse), 32'd0);
    chk("inj_locked_1", 32'(locked), 32'd0);
    count = 4'd10;
    tick();
`ifdef PPC_CHK_RESYNC_EN
    chk("resync_locked", 32'(locked), 32'd1);
    chk("resync_exp", 32'(exp_count), 32'd11);
`else
    chk("resync_locked", 32'(locked), 32'd0);
    chk("resync_exp", 32'(exp_count), 32'd8);
`endif
    chk("resync_sticky", 32'(err_sticky), 32'd1);
    chk("resync_pulse", 32'(err_pulse), 32'd0);

    // Illegal sample during ACQUIRE: 15 while heading up.
    do_reset();
    enable = 1'b1; direction = 1'b1; count = 4'd0;
    tick();
    count = 4'd15; direction = 1'b1;
    tick();
    chk("acq_pulse", 32'(err_pulse), 32'd1);
    chk("acq_locked", 32'(locked), 32'd0);
    chk("acq_sticky", 32'(err_sticky), 32'd1);
    count = 4'd14; direction = 1'b0;
    tick();
    chk("acq_pulse_once", 32'(err_pulse), 32'd0);
    chk("acq_sticky_hold", 32'(err_sticky), 32'd1);

    // Mismatch that also flips direction: error wins, no bounce counted.
    do_reset();
    for (int i = 0; i < 16; i++) drive_step(1'b1);
    chk("mb_pre_bounce", 32'(bounce_cnt), 32'd1);
    enable = 1'b1; count = 4'd14; direction = 1'b1;
    tick();
    chk("mb_bounce", 32'(bounce_cnt), 32'd1);
    chk("mb_pulse", 32'(err_pulse), 32'd1);
    chk("mb_locked", 32'(locked), 32'd0);

    // Holds with enable low are legal; then reset while locked.
    do_reset();
    for (int i = 0; i < 4; i++) drive_step(1'b1);
    drive_step(1'b1);
    chk("hold_exp_a", 32'(exp_count), 32'd5);
    drive_step(1'b0);
    chk("hold_exp_b", 32'(exp_count), 32'd5);
    chk("hold_pulse_b", 32'(err_pulse), 32'd0);
    drive_step(1'b0);
    chk("hold_exp_c", 32'(exp_count), 32'd5);
    drive_step(1'b1);
    chk("hold_exp_d", 32'(exp_count), 32'd6);
    chk("hold_locked", 32'(locked), 32'd1);
    chk("hold_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b1; enable = 1'b1; count = m_cnt; direction = m_dir;
    tick();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_bounce", 32'(bounce_cnt), 32'd0);
    chk("rst_exp", 32'(exp_count), 32'd0);
    rst = 1'b0; enable = 1'b0;
    tick();
    chk("rst_idle_locked", 32'(locked), 32'd0);

    // Long clean run: 259 turns must saturate the bounce counter at 255.
    do_reset();
    for (int i = 0; i < 3900; i++) drive_step(1'b1);
    chk("sat_bounce", 32'(bounce_cnt), 32'd255);
    chk("sat_locked", 32'(locked), 32'd1);
    chk("sat_sticky", 32'(err_sticky), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
